// File: rtl/maxnet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_pkg
// Description : Shared constants and FSM state encoding for the Maxnet loader.
// Revision    : 1.0 - initial release
// ============================================================================
package maxnet_pkg;

    localparam int c_data_w  = 32;
    localparam int c_timeout = 1023;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_WAIT   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/maxnet_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_watchdog
// Description : Saturating wait counter with clear, enable and expired flag.
// Revision    : 1.0 - initial release
// ============================================================================
module maxnet_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic armed,
    output logic expired
);

    localparam int                 c_cnt_w = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT);

    logic [c_cnt_w-1:0] r_count;

    // clear has priority so a fresh wait always starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != c_limit)) begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

    assign armed   = (r_count != '0);
    assign expired = (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/maxnet_loader.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_loader
// Description : Loads four-word frames into a Maxnet datapath, waits for the
//               winner (or a timeout) and hands the result downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module maxnet_loader
    import maxnet_pkg::*;
#(
    parameter int DATA_W  = c_data_w,
    parameter int TIMEOUT = c_timeout
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic [DATA_W-1:0] readData3,
    output logic [DATA_W-1:0] readData4,
    output logic              start,
    input  logic              done,
    input  logic [DATA_W-1:0] maxnumber,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [DATA_W-1:0] result_data,
    output logic              result_err,
    output logic              clamp_flag
);

    state_t            r_state;
    logic [1:0]        r_idx;
    logic [DATA_W-1:0] r_word [4];
    logic              r_in_ready;
    logic              r_start;
    logic              r_result_valid;
    logic [DATA_W-1:0] r_result_data;
    logic              r_result_err;
    logic              r_clamp;

    logic              w_xfer;
    logic              w_neg;
    logic [DATA_W-1:0] w_store;
    logic              w_armed;
    logic              w_expired;

    assign w_xfer  = in_valid && r_in_ready;
    assign w_neg   = in_data[DATA_W-1];
    assign w_store = w_neg ? '0 : in_data;

    maxnet_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (r_state == S_START),
        .en      (r_state == S_WAIT),
        .armed   (w_armed),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_idx          <= 2'd0;
            for (int i = 0; i < 4; i++) r_word[i] <= '0;
            r_in_ready     <= 1'b1;
            r_start        <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_data  <= '0;
            r_result_err   <= 1'b0;
            r_clamp        <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_word[r_idx] <= w_store;
                        // a clamping first word keeps the flag set for its own frame
                        if (w_neg) begin
                            r_clamp <= 1'b1;
                        end else if (r_idx == 2'd0) begin
                            r_clamp <= 1'b0;
                        end
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state    <= S_START;
                            r_start    <= 1'b1;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_START: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // done is blind for the first cycle and beats a coincident timeout
                    if (done && w_armed) begin
                        r_result_data  <= maxnumber;
                        r_result_err   <= 1'b0;
                        r_result_valid <= 1'b1;
                        r_state        <= S_RESULT;
                    end else if (w_expired) begin
                        r_result_data  <= '0;
                        r_result_err   <= 1'b1;
                        r_result_valid <= 1'b1;
                        r_state        <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (result_ready) begin
                        r_result_valid <= 1'b0;
                        r_in_ready     <= 1'b1;
                        r_state        <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign start        = r_start;
    assign result_valid = r_result_valid;
    assign result_data  = r_result_data;
    assign result_err   = r_result_err;
    assign clamp_flag   = r_clamp;
    assign readData1    = r_word[0];
    assign readData2    = r_word[1];
    assign readData3    = r_word[2];
    assign readData4    = r_word[3];

endmodule
`default_nettype wire
